// File: rtl/seg7_reader.sv
// seg7_reader: recovers the four digits shown on a multiplexed, active-low
// 7-segment bus, qualifying each digit by stability and emitting whole frames.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   seg[6:0]    - segment lines A..G (bit6 = A), active-low, async to clk
//   an[3:0]     - digit anodes, active-low, an[i] selects digit i, async
//   digits      - last complete frame, digit i at [4i+3:4i]
//   frame_valid - one-cycle pulse when digits updates
//   frame_err   - some digit of the last frame was not a legal pattern
//   timeout     - one-cycle pulse when a partial frame is thrown away
module seg7_reader #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  // {err, code}; blank reads as F, anything unknown as E with err set
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    unique case (s)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
      7'b1111111: r = 5'h0F;
      default:    r = 5'h1E;
    endcase
    return r;
  endfunction

  logic [6:0]    seg_m_q, seg_s_q;
  logic [3:0]    an_m_q, an_s_q;
  logic [10:0]   prev_q, prev_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    err_q, err_d;
  logic [15:0]   code_q, code_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   digits_q, digits_d;
  logic          fv_q, fv_d;
  logic          ferr_q, ferr_d;
  logic          tmo_q, tmo_d;

  logic          qual;
  logic [1:0]    idx;
  logic          dec_err;
  logic [3:0]    dec_code;
  logic          capture;
  logic          complete;
  logic [15:0]   code_new;
  logic [3:0]    err_new;

  always_comb begin
    qual = $onehot(~an_s_q);
    // index of the low anode; only meaningful when qual
    idx = {~an_s_q[3] | ~an_s_q[2],
           ~an_s_q[3] | ~an_s_q[1]};
    {dec_err, dec_code} = decode(seg_s_q);
    prev_d = {an_s_q, seg_s_q};

    cnt_d = cnt_q;
    if (!qual || prev_d != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
    // fires only on the step into CNT_MAX, so a held digit is taken once
    capture = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

    code_new = code_q;
    code_new[4*idx +: 4] = dec_code;
    err_new = err_q;
    err_new[idx] = dec_err;
    complete = capture &&
      ((mask_q | (4'b0001 << idx)) == 4'hF);

    code_d   = code_q;
    err_d    = err_q;
    mask_d   = mask_q;
    tcnt_d   = tcnt_q;
    digits_d = digits_q;
    ferr_d   = ferr_q;
    fv_d     = 1'b0;
    tmo_d    = 1'b0;

    if (mask_q != 4'h0) begin
      if (tcnt_q == TMO_MAX && !complete) begin
        tmo_d  = 1'b1;
        mask_d = 4'h0;
        err_d  = 4'h0;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end

    if (capture) begin
      code_d = code_new;
      if (complete) begin
        digits_d = code_new;
        ferr_d   = |err_new;
        fv_d     = 1'b1;
        mask_d   = 4'h0;
        err_d    = 4'h0;
        tcnt_d   = '0;
      end else begin
        // a capture on a timeout edge starts the next partial frame
        err_d[idx]  = dec_err;
        mask_d[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m_q  <= '0;
      seg_s_q  <= '0;
      an_m_q   <= '0;
      an_s_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      err_q    <= '0;
      code_q   <= '0;
      tcnt_q   <= '0;
      digits_q <= 16'hFFFF;
      fv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      seg_m_q  <= seg;
      seg_s_q  <= seg_m_q;
      an_m_q   <= an;
      an_s_q   <= an_m_q;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      code_q   <= code_d;
      tcnt_q   <= tcnt_d;
      digits_q <= digits_d;
      fv_q     <= fv_d;
      ferr_q   <= ferr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign timeout     = tmo_q;

endmodule
